// File: rtl/fifo_wr_arbiter.sv
// Front-end controller for an 8-deep FIFO: round-robin write arbitration between two
// producers, consumer reads, and a flush/drain mode, with a shadow occupancy count.
module fifo_wr_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned CNT_W      = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req0,
    input  logic [DATA_WIDTH-1:0] din0,
    input  logic                  req1,
    input  logic [DATA_WIDTH-1:0] din1,
    input  logic                  rd_req,
    input  logic                  flush,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_din,
    output logic                  fifo_rd_en,
    output logic                  rd_err,
    output logic                  flush_done,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic                  empty,
    output logic                  busy
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                state, state_d;
    logic                  rr_ptr, rr_ptr_d;
    logic                  gnt0_d, gnt1_d, wr_en_d, rd_en_d, rd_err_d, flush_done_d;
    logic [DATA_WIDTH-1:0] din_d;
    logic [CNT_W-1:0]      count_d;
    logic                  elig0, elig1, sel;

    // Next-state and next-output decode; all results are registered below.
    always_comb begin
        state_d      = state;
        rr_ptr_d     = rr_ptr;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        wr_en_d      = 1'b0;
        rd_en_d      = 1'b0;
        rd_err_d     = 1'b0;
        flush_done_d = 1'b0;
        din_d        = fifo_din;
        sel          = 1'b0;
        // A producer still holding req during its grant cycle must not be written twice.
        elig0        = req0 & ~gnt0;
        elig1        = req1 & ~gnt1;

        case (state)
            INIT: state_d = RUN;
            RUN: begin
                if (flush) begin
                    state_d = FLUSH;
                end else if ((count != FULL_CNT) && (elig0 || elig1)) begin
                    sel      = (elig0 && elig1) ? rr_ptr : elig1;
                    gnt0_d   = ~sel;
                    gnt1_d   = sel;
                    wr_en_d  = 1'b1;
                    din_d    = sel ? din1 : din0;
                    rr_ptr_d = ~sel;
                end
                if (rd_req) begin
                    if (count != '0) begin
                        rd_en_d = 1'b1;
                    end else begin
                        rd_err_d = 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (count != '0) begin
                    rd_en_d = 1'b1;
                end else begin
                    flush_done_d = 1'b1;
                    state_d      = RUN;
                end
            end
            default: state_d = INIT;
        endcase

        // Write is gated on count<DEPTH and read on count>0, so this cannot wrap.
        count_d = count + CNT_W'(wr_en_d) - CNT_W'(rd_en_d);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= INIT;
            rr_ptr     <= 1'b0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            fifo_wr_en <= 1'b0;
            fifo_din   <= '0;
            fifo_rd_en <= 1'b0;
            rd_err     <= 1'b0;
            flush_done <= 1'b0;
            count      <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            rr_ptr     <= rr_ptr_d;
            gnt0       <= gnt0_d;
            gnt1       <= gnt1_d;
            fifo_wr_en <= wr_en_d;
            fifo_din   <= din_d;
            fifo_rd_en <= rd_en_d;
            rd_err     <= rd_err_d;
            flush_done <= flush_done_d;
            count      <= count_d;
            full       <= (count_d == FULL_CNT);
            empty      <= (count_d == '0);
            busy       <= (state_d == FLUSH);
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed, table-driven bench for fifo_wr_arbiter with hand-written reset-during-flush sequence.
module tb_fifo_wr_arbiter;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 4;
    localparam int NVEC = 30;

    // Expected flag bit positions: {gnt0,gnt1,wr_en,rd_en,rd_err,flush_done,full,empty,busy}
    localparam logic [8:0] G0 = 9'd256;
    localparam logic [8:0] G1 = 9'd128;
    localparam logic [8:0] WR = 9'd64;
    localparam logic [8:0] RD = 9'd32;
    localparam logic [8:0] ER = 9'd16;
    localparam logic [8:0] DN = 9'd8;
    localparam logic [8:0] FL = 9'd4;
    localparam logic [8:0] EM = 9'd2;
    localparam logic [8:0] BY = 9'd1;

    localparam logic [DW-1:0] DA = 32'h0000_00A0;
    localparam logic [DW-1:0] DB = 32'h0000_00B1;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            req0 = 1'b0, req1 = 1'b0, rd_req = 1'b0, flush = 1'b0;
    logic [DW-1:0]   din0 = '0, din1 = '0;
    logic            gnt0, gnt1, fifo_wr_en, fifo_rd_en, rd_err, flush_done, full, empty, busy;
    logic [DW-1:0]   fifo_din;
    logic [CNT_W-1:0] count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic            r0, r1, rd, fl;
        logic [DW-1:0]   d0, d1;
        logic [8:0]      ef;
        logic [CNT_W-1:0] ec;
        logic [DW-1:0]   ed;
    } vec_t;

    vec_t vecs [NVEC];

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .din0(din0), .req1(req1), .din1(din1),
        .rd_req(rd_req), .flush(flush),
        .gnt0(gnt0), .gnt1(gnt1),
        .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_rd_en(fifo_rd_en),
        .rd_err(rd_err), .flush_done(flush_done),
        .count(count), .full(full), .empty(empty), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r0, input logic r1, input logic rd, input logic fl,
                                input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                input logic [8:0] ef, input int ec, input logic [DW-1:0] ed);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.rd = rd; v.fl = fl;
        v.d0 = d0; v.d1 = d1;
        v.ef = ef; v.ec = CNT_W'(ec); v.ed = ed;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [8:0] ef, input logic [CNT_W-1:0] ec,
                         input logic chk_din, input logic [DW-1:0] ed);
        logic [8:0] af;
        af = {gnt0, gnt1, fifo_wr_en, fifo_rd_en, rd_err, flush_done, full, empty, busy};
        tests++;
        if (af !== ef || count !== ec || (chk_din && fifo_din !== ed)) begin
            fails++;
            $display("FAIL %s: got flags=%b count=%0d din=%h, expected flags=%b count=%0d din=%h",
                     name, af, count, fifo_din, ef, ec, ed);
        end
    endtask

    initial begin
        // Vector i: inputs driven for one cycle, expected outputs after the following edge.
        vecs[0]  = mk(1, 1, 0, 0, DA, DB, EM,          0, '0);  // INIT: no grant
        vecs[1]  = mk(1, 1, 0, 0, DA, DB, G0|WR,       1, DA);
        vecs[2]  = mk(1, 1, 0, 0, DA, DB, G1|WR,       2, DB);
        vecs[3]  = mk(1, 1, 0, 0, DA, DB, G0|WR,       3, DA);
        vecs[4]  = mk(1, 1, 0, 0, DA, DB, G1|WR,       4, DB);
        vecs[5]  = mk(1, 1, 0, 0, DA, DB, G0|WR,       5, DA);
        vecs[6]  = mk(1, 1, 0, 0, DA, DB, G1|WR,       6, DB);
        vecs[7]  = mk(1, 1, 0, 0, DA, DB, G0|WR,       7, DA);
        vecs[8]  = mk(1, 1, 0, 0, DA, DB, G1|WR|FL,    8, DB);
        vecs[9]  = mk(1, 1, 0, 0, DA, DB, FL,          8, '0);  // full: wait
        vecs[10] = mk(0, 1, 1, 0, DA, DB, RD,          7, '0);  // read does not free space this cycle
        vecs[11] = mk(0, 1, 0, 0, DA, 32'hDEAD_BEEF, G1|WR|FL, 8, 32'hDEAD_BEEF);
        vecs[12] = mk(0, 0, 1, 0, DA, DB, RD,          7, '0);
        vecs[13] = mk(1, 0, 1, 0, 32'h5555_AAAA, DB, G0|WR|RD, 7, 32'h5555_AAAA);
        vecs[14] = mk(0, 0, 1, 0, DA, DB, RD,          6, '0);
        vecs[15] = mk(0, 0, 1, 0, DA, DB, RD,          5, '0);
        vecs[16] = mk(1, 0, 0, 1, DA, DB, BY,          5, '0);  // flush beats grant
        vecs[17] = mk(1, 0, 0, 0, DA, DB, RD|BY,       4, '0);
        vecs[18] = mk(1, 0, 1, 1, DA, DB, RD|BY,       3, '0);  // flush/rd_req ignored
        vecs[19] = mk(1, 0, 0, 0, DA, DB, RD|BY,       2, '0);
        vecs[20] = mk(1, 0, 0, 0, DA, DB, RD|BY,       1, '0);
        vecs[21] = mk(1, 0, 0, 0, DA, DB, RD|BY|EM,    0, '0);
        vecs[22] = mk(1, 0, 1, 0, DA, DB, DN|EM,       0, '0);  // flush_done, no rd_err
        vecs[23] = mk(1, 0, 0, 0, 32'h1234_5678, DB, G0|WR, 1, 32'h1234_5678);
        vecs[24] = mk(1, 0, 1, 0, DA, DB, RD|EM,       0, '0);  // req0 masked after gnt0
        vecs[25] = mk(0, 0, 1, 0, DA, DB, ER|EM,       0, '0);  // read while empty
        vecs[26] = mk(0, 0, 0, 0, DA, DB, EM,          0, '0);
        vecs[27] = mk(1, 1, 0, 0, DA, DB, G1|WR,       1, DB);  // rr_ptr moved by single grants
        vecs[28] = mk(1, 1, 0, 0, DA, DB, G0|WR,       2, DA);
        vecs[29] = mk(0, 0, 0, 0, DA, DB, 9'd0,        2, '0);

        repeat (3) @(posedge clk);
        #1;
        check("reset", EM, 0, 1'b1, '0);
        #3 reset_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            req0 = vecs[i].r0; req1 = vecs[i].r1; rd_req = vecs[i].rd; flush = vecs[i].fl;
            din0 = vecs[i].d0; din1 = vecs[i].d1;
            step();
            check($sformatf("vec[%0d]", i), vecs[i].ef, vecs[i].ec, vecs[i].ef[6], vecs[i].ed);
        end

        // Reset asserted mid-flush at count=3.
        req0 = 1'b1; req1 = 1'b0; rd_req = 1'b0; flush = 1'b0; din0 = 32'hCAFE_0001;
        step();
        check("prefill", G0|WR, 3, 1'b1, 32'hCAFE_0001);
        req0 = 1'b0; flush = 1'b1;
        step();
        check("flush_entry", BY, 3, 1'b0, '0);
        flush = 1'b0; req1 = 1'b1; din1 = 32'h0BAD_F00D;
        #3 reset_n = 1'b0;
        #1;
        check("async_reset", EM, 0, 1'b1, '0);
        step();
        check("reset_held", EM, 0, 1'b1, '0);
        #3 reset_n = 1'b1;
        step();
        check("init_after_reset", EM, 0, 1'b1, '0);
        step();
        check("run_after_reset", G1|WR, 1, 1'b1, 32'h0BAD_F00D);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
